// File: rtl/result_unloader_pkg.sv
// Shared widths and the unloader state encoding.
// Optional feature macro: UNLOAD_CHECKSUM_EN (adds the CSUM_HI/CSUM_LO states).
package result_unloader_pkg;

    localparam int unsigned DATA_LEN    = 16;
    localparam int unsigned ADDRESS_LEN = 12;
    localparam int unsigned BYTE_LEN    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEND_HI,
        ST_SEND_LO,
`ifdef UNLOAD_CHECKSUM_EN
        ST_CSUM_HI,
        ST_CSUM_LO,
`endif
        ST_DONE
    } unload_state_e;

endpackage

// File: rtl/result_unloader_if.sv
// RAM read port and outgoing byte stream of the result unloader.
// master = unloader side, slave = RAM / UART TX side.
interface result_unloader_if
    import result_unloader_pkg::*;
;
    logic                   ram_read;
    logic [ADDRESS_LEN-1:0] ram_addr;
    logic [DATA_LEN-1:0]    ram_data;
    logic [BYTE_LEN-1:0]    tx_data;
    logic                   tx_valid;
    logic                   tx_ready;

    modport master (
        output ram_read, ram_addr, tx_data, tx_valid,
        input  ram_data, tx_ready
    );

    modport slave (
        input  ram_read, ram_addr, tx_data, tx_valid,
        output ram_data, tx_ready
    );

endinterface

// File: rtl/result_unloader_word_serializer.sv
// Holds one 16-bit word and presents it as a high or low byte on a valid/ready stream.
// The controlling FSM decides which byte is offered and when.
module word_serializer
    import result_unloader_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_i,
    input  logic [DATA_LEN-1:0] word_i,
    input  logic                send_i,
    input  logic                lo_i,
    input  logic                tx_ready_i,
    output logic [BYTE_LEN-1:0] tx_data_o,
    output logic                tx_valid_o,
    output logic                xfer_o
);

    logic [DATA_LEN-1:0] word_q;
    logic [DATA_LEN-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (load_i) begin
            word_d = word_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    // Data is forced to zero when nothing is offered so the stream idles clean.
    assign tx_valid_o = send_i;
    assign tx_data_o  = !send_i ? '0
                      : (lo_i ? word_q[BYTE_LEN-1:0] : word_q[DATA_LEN-1:BYTE_LEN]);
    assign xfer_o     = send_i & tx_ready_i;

endmodule

// File: rtl/result_unloader.sv
// Unloads the result region of the shared RAM as an MSB-first byte stream once the processor finishes.
// Optional feature macro: UNLOAD_CHECKSUM_EN (appends a 16-bit word sum after the data).
module result_unloader
    import result_unloader_pkg::*;
#(
    parameter int unsigned RESULT_BASE  = 2048,
    parameter int unsigned RESULT_WORDS = 225
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               finish_process,
    result_unloader_if.master  bus,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CNT_W = (RESULT_WORDS == 0) ? 1 : $clog2(RESULT_WORDS + 1);

    if (DATA_LEN != 16) begin : g_width_chk
        $error("result_unloader: DATA_LEN must be 16");
    end
    if (64'(RESULT_BASE) + 64'(RESULT_WORDS) > (64'd1 << ADDRESS_LEN)) begin : g_range_chk
        $error("result_unloader: result region exceeds the RAM address space");
    end

    unload_state_e       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fin_q;
    logic                start;
    logic                ser_load, ser_send, ser_lo, ser_xfer;
    logic [DATA_LEN-1:0] ser_word;
    logic                last_word;
`ifdef UNLOAD_CHECKSUM_EN
    logic [DATA_LEN-1:0] csum_q, csum_d;
`endif

    assign start     = finish_process & ~fin_q;
    assign last_word = (32'(cnt_q) + 32'd1) == 32'(RESULT_WORDS);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
`ifdef UNLOAD_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= finish_process;
`ifdef UNLOAD_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
`ifdef UNLOAD_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        bus.ram_read = 1'b0;
        bus.ram_addr = '0;
        busy         = 1'b0;
        done         = 1'b0;
        ser_load     = 1'b0;
        ser_word     = '0;
        ser_send     = 1'b0;
        ser_lo       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy  = 1'b1;
                    cnt_d = '0;
`ifdef UNLOAD_CHECKSUM_EN
                    csum_d = '0;
`endif
                    if (RESULT_WORDS == 0) begin
`ifdef UNLOAD_CHECKSUM_EN
                        ser_load = 1'b1;
                        state_d  = ST_CSUM_HI;
`else
                        state_d  = ST_DONE;
`endif
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                busy         = 1'b1;
                bus.ram_read = 1'b1;
                bus.ram_addr = ADDRESS_LEN'(RESULT_BASE) + ADDRESS_LEN'(cnt_q);
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                busy     = 1'b1;
                ser_load = 1'b1;
                ser_word = bus.ram_data;
`ifdef UNLOAD_CHECKSUM_EN
                csum_d   = csum_q + bus.ram_data;
`endif
                state_d  = ST_SEND_HI;
            end
            ST_SEND_HI: begin
                busy     = 1'b1;
                ser_send = 1'b1;
                if (ser_xfer) begin
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                busy     = 1'b1;
                ser_send = 1'b1;
                ser_lo   = 1'b1;
                if (ser_xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_word) begin
`ifdef UNLOAD_CHECKSUM_EN
                        // Reload the serializer with the finished sum on the last byte transfer.
                        ser_load = 1'b1;
                        ser_word = csum_q;
                        state_d  = ST_CSUM_HI;
`else
                        state_d  = ST_DONE;
`endif
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
`ifdef UNLOAD_CHECKSUM_EN
            ST_CSUM_HI: begin
                busy     = 1'b1;
                ser_send = 1'b1;
                if (ser_xfer) begin
                    state_d = ST_CSUM_LO;
                end
            end
            ST_CSUM_LO: begin
                busy     = 1'b1;
                ser_send = 1'b1;
                ser_lo   = 1'b1;
                if (ser_xfer) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                done = 1'b1;
                if (!finish_process) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    word_serializer u_ser (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (ser_load),
        .word_i     (ser_word),
        .send_i     (ser_send),
        .lo_i       (ser_lo),
        .tx_ready_i (bus.tx_ready),
        .tx_data_o  (bus.tx_data),
        .tx_valid_o (bus.tx_valid),
        .xfer_o     (ser_xfer)
    );

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: a per-cycle vector table for the nominal unload,
// plus hand-written sequences for backpressure, re-trigger, mid-unload reset and zero words.
module tb_result_unloader;
    import result_unloader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic fin_a, busy_a, done_a;
    logic fin_b, busy_b, done_b;

    result_unloader_if ifa ();
    result_unloader_if ifb ();

    result_unloader #(.RESULT_BASE(2048), .RESULT_WORDS(3)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .finish_process (fin_a),
        .bus            (ifa),
        .busy           (busy_a),
        .done           (done_a)
    );

    result_unloader #(.RESULT_BASE(2048), .RESULT_WORDS(0)) u_dut0 (
        .clk            (clk),
        .reset_n        (reset_n),
        .finish_process (fin_b),
        .bus            (ifb),
        .busy           (busy_b),
        .done           (done_b)
    );

    logic [15:0] mem [0:4095];

    // Synchronous-read RAM shared by both instances.
    always @(posedge clk) begin
        if (ifa.ram_read) ifa.ram_data <= mem[ifa.ram_addr];
        if (ifb.ram_read) ifb.ram_data <= mem[ifb.ram_addr];
    end

    logic [7:0] bytes_a[$];
    logic [7:0] bytes_b[$];
    int         reads_a = 0;
    int         reads_b = 0;

    always @(posedge clk) begin
        if (reset_n && ifa.tx_valid && ifa.tx_ready) bytes_a.push_back(ifa.tx_data);
        if (reset_n && ifb.tx_valid && ifb.tx_ready) bytes_b.push_back(ifb.tx_data);
        if (reset_n && ifa.ram_read) reads_a++;
        if (reset_n && ifb.ram_read) reads_b++;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fin;
        logic        rdy;
        logic        rr;
        logic [11:0] addr;
        logic        v;
        logic [7:0]  d;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_bytes[$];

    task automatic add(input logic fin, input logic rdy, input logic rr, input logic [11:0] addr,
                       input logic v, input logic [7:0] d, input logic b, input logic dn);
        vec_t e;
        e.fin = fin; e.rdy = rdy; e.rr = rr; e.addr = addr;
        e.v = v; e.d = d; e.busy = b; e.done = dn;
        vecs.push_back(e);
    endtask

    task automatic chk_stream(input string name, input bit sel_b);
        int n;
        n = sel_b ? bytes_b.size() : bytes_a.size();
        chk($sformatf("%s_len", name), 32'(n), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size(); i++) begin
            chk($sformatf("%s_b%0d", name, i),
                (i < n) ? 32'(sel_b ? bytes_b[i] : bytes_a[i]) : 32'hFFFF_FFFF,
                32'(exp_bytes[i]));
        end
    endtask

    task automatic run_until_done(input string name, input int budget);
        for (int c = 0; c < budget; c++) begin
            #1;
            if (done_a) break;
            step();
        end
        chk($sformatf("%s_done", name), 32'(done_a), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] csum;
        logic        pv, pr;
        logic [7:0]  pd;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[2048] = 16'h1234;
        mem[2049] = 16'hABCD;
        mem[2050] = 16'h00FF;
        csum = mem[2048] + mem[2049] + mem[2050];

        exp_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF};
`ifdef UNLOAD_CHECKSUM_EN
        exp_bytes.push_back(csum[15:8]);
        exp_bytes.push_back(csum[7:0]);
`endif

        //   fin rdy rr addr     v  data   busy done
        add(1, 1, 0, 12'd0,    0, 8'h00, 1, 0);
        add(1, 1, 1, 12'd2048, 0, 8'h00, 1, 0);
        add(1, 1, 0, 12'd0,    0, 8'h00, 1, 0);
        add(1, 1, 0, 12'd0,    1, 8'h12, 1, 0);
        add(1, 1, 0, 12'd0,    1, 8'h34, 1, 0);
        add(1, 1, 1, 12'd2049, 0, 8'h00, 1, 0);
        add(1, 1, 0, 12'd0,    0, 8'h00, 1, 0);
        add(1, 1, 0, 12'd0,    1, 8'hAB, 1, 0);
        add(1, 1, 0, 12'd0,    1, 8'hCD, 1, 0);
        add(1, 1, 1, 12'd2050, 0, 8'h00, 1, 0);
        add(1, 1, 0, 12'd0,    0, 8'h00, 1, 0);
        add(1, 1, 0, 12'd0,    1, 8'h00, 1, 0);
        add(1, 1, 0, 12'd0,    1, 8'hFF, 1, 0);
`ifdef UNLOAD_CHECKSUM_EN
        add(1, 1, 0, 12'd0,    1, csum[15:8], 1, 0);
        add(1, 1, 0, 12'd0,    1, csum[7:0],  1, 0);
`endif
        add(1, 1, 0, 12'd0,    0, 8'h00, 0, 1);
        add(0, 1, 0, 12'd0,    0, 8'h00, 0, 1);
        add(0, 1, 0, 12'd0,    0, 8'h00, 0, 0);

        // Reset state
        reset_n = 1'b0; fin_a = 1'b0; fin_b = 1'b0;
        ifa.tx_ready = 1'b1; ifb.tx_ready = 1'b1;
        step(); step();
        #1;
        chk("rst_ram_read", 32'(ifa.ram_read), 32'd0);
        chk("rst_ram_addr", 32'(ifa.ram_addr), 32'd0);
        chk("rst_tx_valid", 32'(ifa.tx_valid), 32'd0);
        chk("rst_tx_data",  32'(ifa.tx_data),  32'd0);
        chk("rst_busy",     32'(busy_a),       32'd0);
        chk("rst_done",     32'(done_a),       32'd0);
        chk("rst0_busy",    32'(busy_b),       32'd0);
        reset_n = 1'b1;
        step();

        // Nominal unload, cycle by cycle
        bytes_a.delete(); reads_a = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            fin_a = vecs[i].fin;
            ifa.tx_ready = vecs[i].rdy;
            #1;
            chk($sformatf("t1_c%0d_rr",   i), 32'(ifa.ram_read), 32'(vecs[i].rr));
            chk($sformatf("t1_c%0d_addr", i), 32'(ifa.ram_addr), 32'(vecs[i].addr));
            chk($sformatf("t1_c%0d_v",    i), 32'(ifa.tx_valid), 32'(vecs[i].v));
            chk($sformatf("t1_c%0d_d",    i), 32'(ifa.tx_data),  32'(vecs[i].d));
            chk($sformatf("t1_c%0d_busy", i), 32'(busy_a),       32'(vecs[i].busy));
            chk($sformatf("t1_c%0d_done", i), 32'(done_a),       32'(vecs[i].done));
            step();
        end
        chk_stream("t1", 1'b0);
        chk("t1_reads", 32'(reads_a), 32'd3);

        // Backpressure: tx_ready high one cycle in three
        bytes_a.delete(); reads_a = 0;
        pv = 1'b0; pr = 1'b0; pd = 8'h00;
        fin_a = 1'b1;
        for (int c = 0; c < 200; c++) begin
            ifa.tx_ready = (c % 3 == 2);
            #1;
            if (pv && !pr) begin
                chk($sformatf("t2_c%0d_hold_v", c), 32'(ifa.tx_valid), 32'd1);
                chk($sformatf("t2_c%0d_hold_d", c), 32'(ifa.tx_data),  32'(pd));
            end
            pv = ifa.tx_valid; pr = ifa.tx_ready; pd = ifa.tx_data;
            if (done_a) break;
            step();
        end
        chk("t2_done", 32'(done_a), 32'd1);
        chk_stream("t2", 1'b0);
        chk("t2_reads", 32'(reads_a), 32'd3);
        ifa.tx_ready = 1'b1;
        fin_a = 1'b0;
        step(); step();

        // Re-triggering during an unload is ignored; a fresh edge after done repeats the stream
        bytes_a.delete(); reads_a = 0;
        for (int c = 0; c < 100; c++) begin
            fin_a = !(c == 3 || c == 4 || c == 7);
            #1;
            if (done_a) break;
            step();
        end
        chk("t3a_done", 32'(done_a), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk($sformatf("t3_hold%0d_done", k), 32'(done_a), 32'd1);
            chk($sformatf("t3_hold%0d_rr",   k), 32'(ifa.ram_read), 32'd0);
        end
        chk_stream("t3a", 1'b0);
        chk("t3a_reads", 32'(reads_a), 32'd3);
        fin_a = 1'b0;
        step();
        bytes_a.delete(); reads_a = 0;
        fin_a = 1'b1;
        run_until_done("t3b", 100);
        chk_stream("t3b", 1'b0);
        chk("t3b_reads", 32'(reads_a), 32'd3);
        fin_a = 1'b0;
        step(); step();

        // Reset while the low byte of the second word is on the bus
        fin_a = 1'b1;
        for (int c = 0; c < 8; c++) step();
        #1;
        chk("t4_pre_v", 32'(ifa.tx_valid), 32'd1);
        chk("t4_pre_d", 32'(ifa.tx_data),  32'hCD);
        reset_n = 1'b0;
        fin_a   = 1'b0;
        step();
        #1;
        chk("t4_rst_rr",   32'(ifa.ram_read), 32'd0);
        chk("t4_rst_addr", 32'(ifa.ram_addr), 32'd0);
        chk("t4_rst_v",    32'(ifa.tx_valid), 32'd0);
        chk("t4_rst_d",    32'(ifa.tx_data),  32'd0);
        chk("t4_rst_busy", 32'(busy_a),       32'd0);
        chk("t4_rst_done", 32'(done_a),       32'd0);
        reset_n = 1'b1;
        step();
        bytes_a.delete(); reads_a = 0;
        fin_a = 1'b1;
        #1;
        chk("t4_restart_busy", 32'(busy_a), 32'd1);
        step();
        #1;
        chk("t4_restart_rr",   32'(ifa.ram_read), 32'd1);
        chk("t4_restart_addr", 32'(ifa.ram_addr), 32'd2048);
        run_until_done("t4", 100);
        chk_stream("t4", 1'b0);
        chk("t4_reads", 32'(reads_a), 32'd3);
        fin_a = 1'b0;
        step(); step();

        // Zero-word instance
        bytes_b.delete(); reads_b = 0;
        fin_b = 1'b1;
        #1;
        chk("t5_c0_busy", 32'(busy_b), 32'd1);
        chk("t5_c0_done", 32'(done_b), 32'd0);
        step();
        #1;
`ifdef UNLOAD_CHECKSUM_EN
        for (int c = 0; c < 20; c++) begin
            if (done_b) break;
            step();
            #1;
        end
        chk("t5_done", 32'(done_b), 32'd1);
        exp_bytes = '{8'h00, 8'h00};
        chk_stream("t5", 1'b1);
`else
        chk("t5_c1_done",  32'(done_b), 32'd1);
        chk("t5_c1_busy",  32'(busy_b), 32'd0);
        chk("t5_bytes",    32'(bytes_b.size()), 32'd0);
`endif
        chk("t5_reads", 32'(reads_b), 32'd0);
        fin_b = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
